// File: rtl/stack_sched_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack scheduler:
//   - dir_t / DIR_L, DIR_R, DIR_U, DIR_D : one-hot neighbour directions
//                                           (bit0=L, bit1=R, bit2=U, bit3=D)
//   - state_e                            : output FSM states
//   - dir_rot()                          : next-offer rotation U->L->R->D->U
//   - DEPTH_MAX_DEF                      : default maximum stack depth
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int DEPTH_MAX_DEF = 15;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_L = 4'b0001;
    localparam dir_t DIR_R = 4'b0010;
    localparam dir_t DIR_U = 4'b0100;
    localparam dir_t DIR_D = 4'b1000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_e;

    // DIR_ROT mapping: direction offered on the cycle after an unaccepted offer.
    function automatic dir_t dir_rot(input dir_t dir);
        case (dir)
            DIR_U:   return DIR_L;
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_D;
            DIR_D:   return DIR_U;
            default: return DIR_U;
        endcase
    endfunction

endpackage

// File: rtl/stack_sched_if.sv
// -----------------------------------------------------------------------------
// stack_sched_if
// Neighbour/storage handshake bundle of the stack scheduler.
//   rready : neighbour has a value pending      (neighbours -> scheduler)
//   wready : neighbour accepts a value this cycle (neighbours -> scheduler)
//   read   : one-hot pulse, consume granted neighbour value
//   push   : pulse, storage writes the selected neighbour value
//   pop    : pulse, offered top value was taken
//   write  : one-hot offer of the top-of-stack value, 0 when idle
//   count  : current stack depth
// master = scheduler side, slave = neighbour/storage side.
// -----------------------------------------------------------------------------
interface stack_sched_if;

    logic [3:0] rready;
    logic [3:0] wready;
    logic [3:0] read;
    logic       push;
    logic       pop;
    logic [3:0] write;
    logic [3:0] count;

    modport master (
        input  rready,
        input  wready,
        output read,
        output push,
        output pop,
        output write,
        output count
    );

    modport slave (
        output rready,
        output wready,
        input  read,
        input  push,
        input  pop,
        input  write,
        input  count
    );

endinterface

// File: rtl/stack_sched_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Purely combinational 4-way round-robin arbiter.
//   request   : request vector, bit0=L .. bit3=D
//   ptr       : index where the search starts; search wraps D->L
//   grant     : one-hot grant, 0 when nothing is requested
//   grant_idx : index of the granted request (0 when grant is 0)
// -----------------------------------------------------------------------------
module rr_arb4 (
    input  logic [3:0] request,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest requester
    // (first set bit in search order) is the last one written and wins.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (request[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/stack_sched.sv
// -----------------------------------------------------------------------------
// stack_sched
// Scheduler for a neighbour-fed stack. Grants pending neighbour values onto
// the stack round-robin (push side) and offers the top-of-stack value to the
// neighbours in rotation until one accepts it (pop side). Storage and data
// muxing live outside; this block only produces the control pulses and depth.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : stack_sched_if.master (rready/wready in; read/push/pop/write/count out)
//   DEPTH_MAX : maximum stack depth (at most 15, count is 4 bits)
// All outputs are registered. count already reflects the push or pop during
// the cycle its pulse is high.
// -----------------------------------------------------------------------------
module stack_sched
    import stack_pkg::*;
#(
    parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    stack_sched_if.master bus
);

    localparam logic [3:0] DEPTH_LIM = 4'(DEPTH_MAX);

    state_e     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    dir_t       offer_dir_q, offer_dir_d;
    dir_t       read_q, read_d;
    logic       push_q, push_d;
    logic       pop_q, pop_d;
    dir_t       write_q, write_d;
    logic [3:0] count_q, count_d;

    logic       accept;
    logic       grant_en;
    logic [3:0] arb_req;
    logic [3:0] grant;
    logic [1:0] grant_idx;

    // A taken offer has priority: the pop owns this cycle and any pending
    // rready is simply retried on the next edge. A full stack also blocks.
    assign accept   = (state_q == S_OFFER) && (|(write_q & bus.wready));
    assign grant_en = !accept && (count_q != DEPTH_LIM);
    assign arb_req  = bus.rready & {4{grant_en}};

    rr_arb4 u_arb (
        .request   (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        offer_dir_d = offer_dir_q;
        write_d     = write_q;
        pop_d       = 1'b0;
        read_d      = grant;
        push_d      = |grant;
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;

        if (|grant) begin
            rr_ptr_d = grant_idx + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                // Skip one cycle after a pop so the new top settles in storage.
                if ((count_q != 4'd0) && !pop_q) begin
                    state_d = S_OFFER;
                    write_d = offer_dir_q;
                end
            end
            S_OFFER: begin
                if (accept) begin
                    pop_d       = 1'b1;
                    write_d     = '0;
                    offer_dir_d = DIR_U;
                    state_d     = S_IDLE;
                end else begin
                    write_d     = dir_rot(write_q);
                    offer_dir_d = dir_rot(write_q);
                end
            end
            default: begin
                state_d = S_IDLE;
                write_d = '0;
            end
        endcase

        // Push and pop are exclusive by construction; both ends saturate.
        if (push_d && (count_q != DEPTH_LIM)) begin
            count_d = count_q + 4'd1;
        end else if (pop_d && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 2'd0;
            offer_dir_q <= DIR_U;
            read_q      <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            write_q     <= '0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            offer_dir_q <= offer_dir_d;
            read_q      <= read_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            write_q     <= write_d;
            count_q     <= count_d;
        end
    end

    assign bus.read  = read_q;
    assign bus.push  = push_q;
    assign bus.pop   = pop_q;
    assign bus.write = write_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_stack_sched.sv
// -----------------------------------------------------------------------------
// tb_stack_sched
// Directed self-checking bench for stack_sched. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_stack_sched;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stack_sched_if bus ();

    stack_sched #(.DEPTH_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released just after a falling edge: the next edge is the first.
    task automatic apply_reset();
        bus.rready = '0;
        bus.wready = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.rready = 4'hF;
        bus.wready = '0;
        rst = 1'b1;
        #1;
        checks++; if (bus.read !== 4'h0) begin errors++; $display("FAIL reset_read: got %b expected 0000", bus.read); end
        checks++; if (bus.push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", bus.push); end
        checks++; if (bus.pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", bus.pop); end
        checks++; if (bus.write !== 4'h0) begin errors++; $display("FAIL reset_write: got %b expected 0000", bus.write); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        tick();
        checks++; if (bus.read !== 4'h0) begin errors++; $display("FAIL reset_held_read: got %b expected 0000", bus.read); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (bus.read !== DIR_L) begin errors++; $display("FAIL reset_first_grant: got %b expected %b", bus.read, DIR_L); end
    endtask

    task automatic test_fill();
        dir_t exp_read  [4] = '{DIR_L, DIR_R, DIR_U, DIR_D};
        dir_t exp_write [4] = '{4'h0, DIR_U, DIR_L, DIR_R};
        apply_reset();
        bus.rready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.read !== exp_read[i]) begin errors++; $display("FAIL fill_read[%0d]: got %b expected %b", i, bus.read, exp_read[i]); end
            checks++; if (bus.push !== 1'b1) begin errors++; $display("FAIL fill_push[%0d]: got %b expected 1", i, bus.push); end
            checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); end
            checks++; if (bus.write !== exp_write[i]) begin errors++; $display("FAIL fill_write[%0d]: got %b expected %b", i, bus.write, exp_write[i]); end
        end
        bus.rready = '0;
        tick();
        checks++; if (bus.read !== 4'h0 || bus.push !== 1'b0) begin errors++; $display("FAIL fill_idle: got read=%b push=%b expected 0000/0", bus.read, bus.push); end
        checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL fill_final_count: got %0d expected 4", bus.count); end
        checks++; if (bus.write !== DIR_D) begin errors++; $display("FAIL fill_final_write: got %b expected %b", bus.write, DIR_D); end
    endtask

    task automatic test_rotate();
        dir_t exp_write [5] = '{DIR_U, DIR_L, DIR_R, DIR_D, DIR_U};
        apply_reset();
        bus.rready = 4'hF;
        repeat (3) tick();
        bus.rready = '0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.write !== exp_write[i]) begin errors++; $display("FAIL rotate_write[%0d]: got %b expected %b", i, bus.write, exp_write[i]); end
            checks++; if (bus.pop !== 1'b0) begin errors++; $display("FAIL rotate_pop[%0d]: got %b expected 0", i, bus.pop); end
            checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL rotate_count[%0d]: got %0d expected 3", i, bus.count); end
        end
    endtask

    task automatic test_pop_wins();
        apply_reset();
        bus.rready = 4'hF;
        repeat (2) tick();
        bus.rready = '0;
        tick();
        checks++; if (bus.write !== DIR_L || bus.count !== 4'd2) begin errors++; $display("FAIL popwin_setup: got write=%b count=%0d expected 0001/2", bus.write, bus.count); end
        bus.wready = DIR_L;
        bus.rready = DIR_U;
        tick();
        checks++; if (bus.pop !== 1'b1) begin errors++; $display("FAIL popwin_pop: got %b expected 1", bus.pop); end
        checks++; if (bus.push !== 1'b0 || bus.read !== 4'h0) begin errors++; $display("FAIL popwin_nopush: got push=%b read=%b expected 0/0000", bus.push, bus.read); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL popwin_count: got %0d expected 1", bus.count); end
        checks++; if (bus.write !== 4'h0) begin errors++; $display("FAIL popwin_write: got %b expected 0000", bus.write); end
        bus.wready = '0;
        tick();
        checks++; if (bus.read !== DIR_U || bus.push !== 1'b1) begin errors++; $display("FAIL popwin_retry: got read=%b push=%b expected 0100/1", bus.read, bus.push); end
        checks++; if (bus.pop !== 1'b0 || bus.count !== 4'd2) begin errors++; $display("FAIL popwin_after: got pop=%b count=%0d expected 0/2", bus.pop, bus.count); end
        checks++; if (bus.write !== 4'h0) begin errors++; $display("FAIL popwin_gap: got write=%b expected 0000", bus.write); end
        bus.rready = '0;
        tick();
        checks++; if (bus.write !== DIR_U) begin errors++; $display("FAIL popwin_reoffer: got %b expected %b", bus.write, DIR_U); end
    endtask

    task automatic test_full();
        apply_reset();
        bus.rready = DIR_L;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if (bus.read !== DIR_L || bus.count !== 4'(i + 1)) begin errors++; $display("FAIL full_push[%0d]: got read=%b count=%0d expected 0001/%0d", i, bus.read, bus.count, i + 1); end
        end
        tick();
        checks++; if (bus.read !== 4'h0 || bus.push !== 1'b0) begin errors++; $display("FAIL full_blocked: got read=%b push=%b expected 0000/0", bus.read, bus.push); end
        checks++; if (bus.count !== 4'd15) begin errors++; $display("FAIL full_sat: got %0d expected 15", bus.count); end
        bus.wready = 4'hF;
        tick();
        checks++; if (bus.pop !== 1'b1 || bus.count !== 4'd14) begin errors++; $display("FAIL full_pop: got pop=%b count=%0d expected 1/14", bus.pop, bus.count); end
        checks++; if (bus.read !== 4'h0) begin errors++; $display("FAIL full_pop_noread: got %b expected 0000", bus.read); end
        bus.wready = '0;
        tick();
        checks++; if (bus.read !== DIR_L || bus.push !== 1'b1 || bus.count !== 4'd15) begin errors++; $display("FAIL full_refill: got read=%b push=%b count=%0d expected 0001/1/15", bus.read, bus.push, bus.count); end
        tick();
        checks++; if (bus.read !== 4'h0 || bus.count !== 4'd15) begin errors++; $display("FAIL full_reblocked: got read=%b count=%0d expected 0000/15", bus.read, bus.count); end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        bus.rready = 4'hF;
        repeat (5) tick();
        checks++; if (bus.count !== 4'd5 || bus.write !== DIR_D) begin errors++; $display("FAIL abort_setup: got count=%0d write=%b expected 5/1000", bus.count, bus.write); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.read !== 4'h0 || bus.push !== 1'b0 || bus.pop !== 1'b0) begin errors++; $display("FAIL abort_pulses: got read=%b push=%b pop=%b expected 0", bus.read, bus.push, bus.pop); end
        checks++; if (bus.write !== 4'h0 || bus.count !== 4'd0) begin errors++; $display("FAIL abort_state: got write=%b count=%0d expected 0000/0", bus.write, bus.count); end
        tick();
        checks++; if (bus.read !== 4'h0 || bus.push !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL abort_held: got read=%b push=%b count=%0d expected 0", bus.read, bus.push, bus.count); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (bus.read !== DIR_L || bus.count !== 4'd1) begin errors++; $display("FAIL abort_first_grant: got read=%b count=%0d expected 0001/1", bus.read, bus.count); end
    endtask

    task automatic test_rr_wrap();
        dir_t exp_read [8] = '{DIR_L, DIR_R, DIR_U, DIR_D, DIR_L, DIR_R, DIR_U, DIR_D};
        int   n [4] = '{0, 0, 0, 0};
        apply_reset();
        bus.rready = DIR_U;
        tick();
        checks++; if (bus.read !== DIR_U) begin errors++; $display("FAIL rr_first_u: got %b expected %b", bus.read, DIR_U); end
        bus.rready = DIR_D;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.read !== DIR_D) begin errors++; $display("FAIL rr_d[%0d]: got %b expected %b", i, bus.read, DIR_D); end
        end
        bus.rready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.read !== exp_read[i]) begin errors++; $display("FAIL rr_all[%0d]: got %b expected %b", i, bus.read, exp_read[i]); end
            checks++; if (bus.push !== (|bus.read)) begin errors++; $display("FAIL rr_consistent[%0d]: got push=%b read=%b", i, bus.push, bus.read); end
            case (bus.read)
                DIR_L:   n[0]++;
                DIR_R:   n[1]++;
                DIR_U:   n[2]++;
                DIR_D:   n[3]++;
                default: ;
            endcase
        end
        for (int d = 0; d < 4; d++) begin
            checks++; if (n[d] !== 2) begin errors++; $display("FAIL rr_fair[%0d]: got %0d grants expected 2", d, n[d]); end
        end
        checks++; if (bus.count !== 4'd12) begin errors++; $display("FAIL rr_count: got %0d expected 12", bus.count); end
    endtask

    initial begin
        bus.rready = '0;
        bus.wready = '0;
        rst = 1'b0;
        test_reset();
        test_fill();
        test_rotate();
        test_pop_wins();
        test_full();
        test_reset_abort();
        test_rr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_sched.md
STACK_SCHED -- requirements
Module: stack_sched

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rready  input  4  neighbour has value pending; bit0=L, bit1=R, bit2=U, bit3=D.
REQ-004 wready  input  4  neighbour accepts value this cycle; same bit order.
REQ-005 read  output  4  one-hot registered pulse; consumes the value of the granted neighbour.
REQ-006 push  output  1  registered pulse; storage writes the selected neighbour value at address count.
REQ-007 pop  output  1  registered pulse; offered top value was taken.
REQ-008 write  output  4  one-hot registered offer of the top-of-stack value, or 0 when idle.
REQ-009 count  output  4  current stack depth, 0..15; storage top address is count-1.
REQ-010 DEPTH_MAX  parameter, default 15  maximum stack depth.

Function
REQ-011 push grant: round-robin over rready; search starts at rr_ptr and wraps D->L; first set bit wins.
REQ-012 after a grant, rr_ptr becomes granted index+1, modulo 4; with no grant, rr_ptr holds.
REQ-013 push/read latency: rready sampled at edge N gives read and push high for the cycle after edge N; both drop after one cycle unless re-granted.
REQ-014 no grant when count==DEPTH_MAX; read=0, push=0, rready left pending.
REQ-015 count increments on a push cycle, decrements on a pop cycle, and never does both in one cycle.
REQ-016 output FSM states: IDLE (write=0) and OFFER (write one-hot).
REQ-017 IDLE->OFFER when count!=0 and no pop occurred the previous cycle; write=offer_dir.
REQ-018 OFFER with (write & wready)!=0: pop=1, count-1, write<=0, offer_dir<=U, ->IDLE.
REQ-019 OFFER without acceptance: write rotates one step per cycle in order U->L->R->D->U.
REQ-020 simultaneous accept and pending rready: pop wins; no push or read that cycle; grant retried next cycle.
REQ-021 push during OFFER without acceptance is allowed; the offered value follows the new top.
REQ-022 count==0 blocks OFFER entry; count==DEPTH_MAX blocks pushes; both limits are saturating, never wrap.
REQ-023 read, push and pop are mutually consistent: read!=0 iff push==1; at most one read bit set.

Reset
REQ-024 reset values: read=0, push=0, pop=0, write=0, count=0, rr_ptr=L, offer_dir=U, FSM=IDLE.
REQ-025 reset asserted mid-offer or mid-push aborts immediately; no pulse is emitted after rst rises.
REQ-026 the first grant after reset release can occur at the first clk edge.

Structure
REQ-027 shared package stack_pkg holds: direction one-hot constants DIR_L/R/U/D, the DIR_ROT next-offer mapping, and the DEPTH_MAX default.
REQ-028 the round-robin arbiter is a separate sub-module rr_arb4: request[3:0], ptr[1:0] -> grant[3:0], grant_idx[1:0]; purely combinational.
REQ-029 stack storage and data muxing stay outside this block.

Verification
REQ-030 After reset, rready=4'b1111 for 4 cycles, no wready -> read sequence L,R,U,D on consecutive cycles; count=4; write=U the cycle after count first becomes nonzero.
REQ-031 count=3, in OFFER, wready=0 for 4 cycles -> write sequence U,L,R,D,U; pop=0; count=3 throughout.
REQ-032 count=2, write=L, wready=4'b0001, rready=4'b0100 in the same cycle -> pop=1, push=0, count=1; next cycle read=U and push=1.
REQ-033 Push until count=15 with rready held -> no further read; one accepted pop -> count=14; pending value then pushed, count=15.
REQ-034 rst asserted mid-OFFER with count=5 -> all outputs 0 and count=0 asynchronously; first post-reset grant goes to L.
REQ-035 rready=4'b1000 for 3 pushes after a grant to U -> each grant goes to D; rr_ptr wraps to L; no starvation with all four requesting over 8 cycles (2 grants each).
